// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path.
//   seq_state_e : sequencer state encodings (visible on ins_seq_ctrl.state)
//   ins_byte_e  : decoder extension-word count field (0-2 valid, 3 reserved)
//   WORD_W      : instruction/ROM word width
//   RESET_PC_DEFAULT : default program counter after reset
package cpu_ctrl_pkg;

    localparam int unsigned WORD_W           = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXT    = 3'd4,
        ST_EXEC   = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        IB_NONE = 2'd0,
        IB_ONE  = 2'd1,
        IB_TWO  = 2'd2,
        IB_RSVD = 2'd3
    } ins_byte_e;

endpackage

// File: rtl/ins_pc_unit.sv
// Program counter register.
// Priority: reset > branch load > increment; increment wraps modulo 2^ADDR_W.
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   inc        : advance pc by one
//   load       : load target (taken branch)
//   target     : branch target address
//   pc         : current program counter
module ins_pc_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ins_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 16-bit CPU.
// Fetches an instruction word over a ROM req/ack handshake, strobes the
// decoder, waits DEC_LAT edges, fetches 0-2 extension words, then hands off
// to the execute stage and applies sequential/branch PC update.
//   run                 : level, allow sequencing (sampled in IDLE / end of EXEC)
//   rom_req/rom_addr    : ROM request, address = pc
//   rom_ack/rom_data    : ROM data valid / data (ack ignored unless requesting)
//   ins_word/ins_load   : latched instruction word / one-cycle decoder strobe
//   ins_byte            : decoded extension-word count
//   ext_word/ext_valid  : latest extension word / one-cycle update pulse
//   exec_start          : one-cycle execute start pulse
//   exec_done, br_taken, br_target : execute completion and branch result
//   pc, state, err      : program counter, FSM state, sticky error flag
// Optional build macro INS_SEQ_WATCHDOG_EN: a wait-cycle watchdog in
// FETCH/EXT/EXEC forces ERR after TIMEOUT cycles without ack/done.
module ins_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       DEC_LAT  = 2,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [15:0]       rom_data,
    output logic [15:0]       ins_word,
    output logic              ins_load,
    input  logic [1:0]        ins_byte,
    output logic [15:0]       ext_word,
    output logic              ext_valid,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(DEC_LAT + 1);

    seq_state_e       cur;
    seq_state_e       nxt;
    logic [CNT_W-1:0] dec_cnt;
    logic [1:0]       ext_cnt;
    logic             exec_seen;
    logic             timeout_hit;
    logic             pc_inc;
    logic             pc_load;

    assign state    = cur;
    assign rom_addr = pc;

    ins_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pc_inc),
        .load   (pc_load),
        .target (br_target),
        .pc     (pc)
    );

    always_comb begin
        nxt        = cur;
        rom_req    = 1'b0;
        ins_load   = 1'b0;
        exec_start = 1'b0;
        err        = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (run) nxt = ST_FETCH;
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    pc_inc = 1'b1;
                    nxt    = ST_LOAD;
                end else if (timeout_hit) begin
                    nxt = ST_ERR;
                end
            end
            ST_LOAD: begin
                ins_load = 1'b1;
                nxt      = ST_DECODE;
            end
            ST_DECODE: begin
                // The counter reaches zero on the same edge that samples
                // ins_byte, so DECODE lasts exactly DEC_LAT cycles.
                if (dec_cnt == CNT_W'(1)) begin
                    if (ins_byte == IB_NONE)      nxt = ST_EXEC;
                    else if (ins_byte == IB_RSVD) nxt = ST_ERR;
                    else                          nxt = ST_EXT;
                end
            end
            ST_EXT: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    pc_inc = 1'b1;
                    if (ext_cnt == 2'd1) nxt = ST_EXEC;
                end else if (timeout_hit) begin
                    nxt = ST_ERR;
                end
            end
            ST_EXEC: begin
                exec_start = !exec_seen;
                if (exec_done) begin
                    pc_load = br_taken;
                    nxt     = run ? ST_FETCH : ST_IDLE;
                end else if (timeout_hit) begin
                    nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                nxt = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= ST_IDLE;
            ins_word  <= '0;
            ext_word  <= '0;
            ext_valid <= 1'b0;
            dec_cnt   <= '0;
            ext_cnt   <= '0;
            exec_seen <= 1'b0;
        end else begin
            cur       <= nxt;
            ext_valid <= 1'b0;
            exec_seen <= (cur == ST_EXEC) && (nxt == ST_EXEC);
            case (cur)
                ST_FETCH: begin
                    if (rom_ack) ins_word <= rom_data;
                end
                ST_LOAD: begin
                    dec_cnt <= CNT_W'(DEC_LAT);
                end
                ST_DECODE: begin
                    dec_cnt <= dec_cnt - CNT_W'(1);
                    if (dec_cnt == CNT_W'(1)) ext_cnt <= ins_byte;
                end
                ST_EXT: begin
                    if (rom_ack) begin
                        ext_word  <= rom_data;
                        ext_valid <= 1'b1;
                        ext_cnt   <= ext_cnt - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INS_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    always_comb begin
        waiting = 1'b0;
        if ((cur == ST_FETCH || cur == ST_EXT) && !rom_ack) waiting = 1'b1;
        if (cur == ST_EXEC && !exec_done)                    waiting = 1'b1;
    end

    // Counts consecutive unanswered wait cycles; the TIMEOUT-th one trips.
    assign timeout_hit = waiting && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (waiting && !timeout_hit) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ins_seq_ctrl.sv
`timescale 1ns/1ps
module tb_ins_seq_ctrl;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEC_LAT = 2;
`ifdef INS_SEQ_WATCHDOG_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [15:0]       rom_data;
    logic [15:0]       ins_word;
    logic              ins_load;
    logic [1:0]        ins_byte;
    logic [15:0]       ext_word;
    logic              ext_valid;
    logic              exec_start;
    logic              exec_done;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              err;

    ins_seq_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000),
        .DEC_LAT  (DEC_LAT),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .ins_word   (ins_word),
        .ins_load   (ins_load),
        .ins_byte   (ins_byte),
        .ext_word   (ext_word),
        .ext_valid  (ext_valid),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .state      (state),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ROM image
    logic [15:0] mem [0:65535];

    // Reference model: instruction-level view of the address stream
    logic [15:0] exp_addr;
    logic [15:0] exp_ins;
    logic [15:0] ext_q[$];
    int          ext_left, cur_n, ext_seen, loads, load_cyc, cyc, instr_done;
    bit          post_done_pending, run_at_done;

    // Environment models (ROM, decoder, execute stage)
    int          ack_lat, req_wait, exec_lat, exec_wait, dec_edges;
    bit          exec_active, br_cfg, spurious, rand_mode, dec_armed, prev_load, done_now;
    logic [15:0] tgt_cfg, dec_word, pc_at_start;

    task automatic model_reset();
        exp_addr = 16'h0000; exp_ins = '0; ext_q.delete();
        ext_left = 0; cur_n = 0; ext_seen = 0; loads = 0; load_cyc = 0;
        post_done_pending = 0; req_wait = 0; exec_active = 0; exec_wait = 0;
        dec_armed = 0; dec_edges = 0; prev_load = 0;
    endtask

    task automatic model_ack();
        check("rom_addr", rom_addr, exp_addr);
        if (ext_left == 0) begin
            exp_ins  = mem[exp_addr];
            cur_n    = int'(exp_ins[13:12]);
            ext_left = (cur_n == 3) ? 0 : cur_n;
            ext_seen = 0;
            loads    = 0;
            ext_q.delete();
        end else begin
            ext_q.push_back(mem[exp_addr]);
            ext_left--;
        end
        exp_addr = exp_addr + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        done_now = 0;
        if (rand_mode) run = ($urandom_range(0, 3) != 0);

        if (post_done_pending) begin
            check("state_after_exec", state, run_at_done ? 32'd1 : 32'd0);
            check("pc_after_exec", pc, exp_addr);
            post_done_pending = 0;
        end

        // decoder: output valid DEC_LAT edges after the load strobe
        if (dec_armed) dec_edges++;
        if (ins_load) begin
            check("ins_load_width", prev_load, 0);
            check("ins_word", ins_word, exp_ins);
            loads++;
            load_cyc  = cyc;
            dec_armed = 1;
            dec_edges = 0;
            dec_word  = ins_word;
        end
        prev_load = ins_load;
        ins_byte  = (dec_armed && dec_edges >= int'(DEC_LAT)) ? dec_word[13:12] : 2'd3;

        if (ext_valid) begin
            ext_seen++;
            if (ext_q.size() == 0) check("ext_valid_spurious", ext_valid, 0);
            else                   check("ext_word", ext_word, ext_q.pop_front());
        end

        if (exec_start) begin
            pc_at_start = pc;
            check("pc_at_exec_start", pc, exp_addr);
            check("ext_count", ext_seen, cur_n);
            check("ins_load_count", loads, 1);
            if (cur_n == 0) check("decode_latency", cyc - load_cyc, DEC_LAT + 1);
            exec_active = 1;
            exec_wait   = 0;
        end

        // ROM responder; data is noise except on the ack cycle
        rom_ack  = 1'b0;
        rom_data = 16'($urandom);
        if (rom_req) begin
            if (req_wait >= ack_lat) begin
                rom_ack  = 1'b1;
                rom_data = mem[rom_addr];
                model_ack();
                req_wait = 0;
                if (rand_mode) ack_lat = $urandom_range(0, 3);
            end else begin
                req_wait++;
            end
        end else begin
            req_wait = 0;
            if (spurious) rom_ack = 1'b1;
        end

        // execute stage; branch lines carry noise unless exec_done
        exec_done = 1'b0;
        br_taken  = 1'($urandom);
        br_target = 16'($urandom);
        if (exec_active) begin
            if (exec_wait >= exec_lat) begin
                exec_done   = 1'b1;
                br_taken    = br_cfg;
                br_target   = tgt_cfg;
                exec_active = 0;
                done_now    = 1;
                instr_done++;
                if (br_cfg) exp_addr = tgt_cfg;
                run_at_done       = run;
                post_done_pending = 1;
                if (rand_mode) begin
                    exec_lat = $urandom_range(0, 3);
                    br_cfg   = ($urandom_range(0, 3) == 0);
                    tgt_cfg  = 16'($urandom);
                end
            end else begin
                exec_wait++;
            end
        end
    endtask

    typedef struct {
        int          ack_lat;
        int          exec_lat;
        bit          br;
        logic [15:0] tgt;
        bit          run;
        logic [15:0] pc_start;
        logic [15:0] next_pc;
    } row_t;

    row_t tbl [6];

    initial begin
        #2ms;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit          seen;
        int          req_cnt;
        logic [15:0] w;

        rst_n = 1'b0; run = 1'b0; rom_ack = 1'b0; rom_data = '0; ins_byte = 2'd3;
        exec_done = 1'b0; br_taken = 1'b0; br_target = '0;
        cyc = 0; instr_done = 0; spurious = 0; rand_mode = 0;
        ack_lat = 0; exec_lat = 0; br_cfg = 0; tgt_cfg = '0; dec_word = '0; pc_at_start = '0;
        run_at_done = 0;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[13:12] == 2'd3) w[13] = 1'b0;
            mem[i] = w;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state, 0);
        check("reset_pc", pc, 16'h0000);
        check("reset_rom_req", rom_req, 0);
        check("reset_ins_word", ins_word, 0);
        check("reset_err", err, 0);
        #2 rst_n = 1'b1;

        // directed program
        mem[16'h0000] = 16'h0105;
        mem[16'h0001] = 16'h2000;
        mem[16'h0002] = 16'hAAAA;
        mem[16'h0003] = 16'h5555;
        mem[16'h0004] = 16'h0C00;
        mem[16'h0040] = 16'h1234;
        mem[16'h0041] = 16'hBEEF;
        mem[16'h0042] = 16'h4001;
        mem[16'hFFFF] = 16'h8000;

        tbl[0] = '{2, 1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0001};
        tbl[1] = '{1, 0, 1'b0, 16'h1234, 1'b1, 16'h0004, 16'h0004};
        tbl[2] = '{0, 2, 1'b1, 16'h0040, 1'b1, 16'h0005, 16'h0040};
        tbl[3] = '{1, 1, 1'b0, 16'h0000, 1'b0, 16'h0042, 16'h0042};
        tbl[4] = '{0, 0, 1'b1, 16'hFFFF, 1'b1, 16'h0043, 16'hFFFF};
        tbl[5] = '{3, 1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};

        for (int r = 0; r < 6; r++) begin
            ack_lat  = tbl[r].ack_lat;
            exec_lat = tbl[r].exec_lat;
            br_cfg   = tbl[r].br;
            tgt_cfg  = tbl[r].tgt;
            run      = tbl[r].run;
            seen     = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                tick();
                if (done_now) seen = 1;
            end
            check($sformatf("row%0d_done", r), seen, 1);
            check($sformatf("row%0d_pc_start", r), pc_at_start, tbl[r].pc_start);
            tick();
            check($sformatf("row%0d_next_pc", r), pc, tbl[r].next_pc);
        end

        // ack without a request is ignored
        spurious = 1;
        repeat (5) tick();
        spurious = 0;
        check("spurious_state", state, 0);
        check("spurious_pc", pc, 16'h0000);
        check("spurious_ins_word", ins_word, 16'h8000);

        // reserved ins_byte encoding locks up in ERR until reset
        mem[16'h0000] = 16'h3105;
        ack_lat = 1;
        run     = 1'b1;
        seen    = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (state == 3'd6) seen = 1;
        end
        check("err_reached", seen, 1);
        check("err_latency", cyc - load_cyc, DEC_LAT + 1);
        check("err_flag", err, 1);
        req_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (rom_req) req_cnt++;
        end
        check("err_no_requests", req_cnt, 0);
        check("err_sticky_state", state, 6);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_state", state, 0);
        check("async_reset_err", err, 0);
        check("async_reset_pc", pc, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run against the reference model
        mem[16'h0000] = 16'h0105;
        rand_mode  = 1;
        ack_lat    = $urandom_range(0, 3);
        exec_lat   = $urandom_range(0, 3);
        br_cfg     = 0;
        tgt_cfg    = '0;
        instr_done = 0;
        repeat (3000) tick();
        rand_mode = 0;
        run       = 1'b0;
        check("random_progress", (instr_done > 100) ? 1 : 0, 1);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (state == 3'd0 && !post_done_pending) seen = 1;
        end
        check("random_drain_idle", seen, 1);
        check("random_no_err", err, 0);

`ifdef INS_SEQ_WATCHDOG_EN
        // withheld ack trips the watchdog after TIMEOUT waiting cycles
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        ack_lat = 100000;
        run     = 1'b1;
        req_cnt = 0;
        seen    = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (rom_req) req_cnt++;
            if (state == 3'd6) seen = 1;
        end
        check("wd_err_reached", seen, 1);
        check("wd_wait_cycles", req_cnt, TB_TIMEOUT);
        check("wd_err_flag", err, 1);
        check("wd_req_dropped", rom_req, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
